lsu_mem_master: RTL and testbench

- Load/store initiator that sits between the execute stage and the word-organised data memory.
- Accepts one byte, halfword or word request at a time from the pipeline.
- Drives a req/ack word-memory interface, doing read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended 64-bit load data and flags misaligned or illegal accesses without touching memory.

---
 rtl/riscv_mem_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/lsu_mem_master.sv | 148 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings and constants for the load/store unit and its lane aligner.
package riscv_mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] BHW_BYTE = 2'd0;
    localparam logic [1:0] BHW_HALF = 2'd1;
    localparam logic [1:0] BHW_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // A size of 3 is illegal and is reported the same way as a misalignment.
    function automatic logic is_misaligned(input logic [1:0] bhw, input logic [1:0] offset);
        logic mis;
        case (bhw)
            BHW_BYTE: mis = 1'b0;
            BHW_HALF: mis = offset[0];
            BHW_WORD: mis = (offset != 2'd0);
            default:  mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the pipeline:
// load extraction with sign/zero extension, and sub-word store merging.
module lsu_lane_align
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        bhw_i,
    input  logic [1:0]        offset_i,
    input  logic              sign_i,
    input  logic [15:0]       wdata_i,
    output logic [XLEN-1:0]   load_o,
    output logic [WORD_W-1:0] merge_o
);

    logic [WORD_W-1:0] shifted;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        load_o  = '0;
        merge_o = word_i;
        case (bhw_i)
            BHW_BYTE: begin
                load_o = {{(XLEN-8){sign_i & shifted[7]}}, shifted[7:0]};
                merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            BHW_HALF: begin
                load_o = {{(XLEN-16){sign_i & shifted[15]}}, shifted[15:0]};
                merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i;
            end
            default: begin
                load_o = {{(XLEN-WORD_W){sign_i & word_i[WORD_W-1]}}, word_i};
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one pipeline request at a time, driven onto a req/ack
// word memory, with read-modify-write for byte and halfword stores.
module lsu_mem_master
    import riscv_mem_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int MADDR_W = XLEN - 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_bhw,
    input  logic               req_sign,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output logic               resp_valid,
    output logic [XLEN-1:0]    resp_rdata,
    output logic               resp_misaligned,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [WORD_W-1:0]  mem_rdata
);

    lsu_state_e         state_q;
    logic [1:0]         offset_q;
    logic [1:0]         bhw_q;
    logic               sign_q;
    logic               write_q;
    logic [15:0]        wdata_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic [XLEN-1:0]    resp_rdata_q;
    logic               resp_mis_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [MADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0]  mem_wdata_q;

    logic [XLEN-1:0]    load_data;
    logic [WORD_W-1:0]  merged_word;

    // Works straight off the memory read word, so results are ready in the ack cycle.
    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .word_i   (mem_rdata),
        .bhw_i    (bhw_q),
        .offset_i (offset_q),
        .sign_i   (sign_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merged_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            offset_q     <= '0;
            bhw_q        <= BHW_BYTE;
            sign_q       <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        offset_q    <= req_addr[1:0];
                        bhw_q       <= req_bhw;
                        sign_q      <= req_sign;
                        write_q     <= req_write;
                        wdata_q     <= req_wdata[15:0];
                        req_ready_q <= 1'b0;
                        if (is_misaligned(req_bhw, req_addr[1:0])) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_mis_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= req_addr[XLEN-1:2];
                            if (req_write && req_bhw == BHW_WORD) begin
                                state_q     <= ST_WR;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= req_wdata[WORD_W-1:0];
                            end else begin
                                state_q  <= ST_RD;
                                mem_we_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (mem_ack) begin
                        if (write_q) begin
                            state_q     <= ST_WR;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= merged_word;
                        end else begin
                            state_q      <= ST_RESP;
                            mem_req_q    <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_mis_q   <= 1'b0;
                            resp_rdata_q <= load_data;
                        end
                    end
                end
                ST_WR: begin
                    if (mem_ack) begin
                        state_q      <= ST_RESP;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_mis_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_mis_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed scenarios plus randomized
// traffic against a byte-level reference model and a req/ack memory responder.
module tb_lsu_mem_master;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_bhw = 2'd0;
    logic        req_sign = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [61:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    lsu_mem_master dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bhw(req_bhw), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory responder ----------------
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    int          ack_delay = 0;
    logic        hold_ack = 1'b0;
    logic        stray_ack = 1'b0;
    int          wait_cnt = 0;
    int          rd_cnt = 0, wr_cnt = 0, req_cycles = 0, stab_err = 0;
    logic [61:0] last_raddr = '0, last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic        prev_req = 1'b0, prev_we = 1'b0;
    logic [61:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    always @(negedge Clk) begin
        if (Reset) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            prev_req = 1'b0;
        end else begin
            if (mem_req) begin
                req_cycles++;
                if (prev_req && mem_addr !== prev_addr) stab_err++;
                if (prev_req && prev_we == mem_we && mem_wdata !== prev_wdata) stab_err++;
            end
            prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
            mem_ack = 1'b0;
            if (stray_ack && !mem_req) begin
                mem_ack = 1'b1;
            end else if (mem_req && !hold_ack) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[5:0]] = mem_wdata;
                        wr_cnt++; last_waddr = mem_addr; last_wdata = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[5:0]];
                        rd_cnt++; last_raddr = mem_addr;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] bhw);
        return (bhw == 2'd0) ? 1 : (bhw == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_mis(input logic [1:0] bhw, input logic [63:0] addr);
        return (bhw == 2'd3) || ((addr % size_bytes(bhw)) != 0);
    endfunction

    function automatic logic [63:0] model_load(input logic [31:0] word, input logic [63:0] addr,
                                              input logic [1:0] bhw, input logic s);
        int          n = size_bytes(bhw);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] v = ({32'd0, word} >> (8 * int'(addr % 4))) & mask;
        if (s && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [63:0] addr,
                                               input logic [1:0] bhw, input logic [63:0] wd);
        logic [31:0] r = old;
        int          off = int'(addr % 4);
        for (int i = 0; i < size_bytes(bhw); i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Issues one request and follows it to its response; lat = cycles from accept to resp_valid.
    task automatic do_req(input logic w, input logic [1:0] bhw, input logic s,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic mis, output int lat,
                          output logic after_valid, output logic after_ready);
        int n = 0;
        @(negedge Clk);
        req_valid = 1'b1; req_write = w; req_bhw = bhw; req_sign = s; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 20) begin @(negedge Clk); n++; end
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(negedge Clk);
        lat = 1;
        while (!resp_valid && lat < 60) begin @(negedge Clk); lat++; end
        if (!resp_valid) lat = -1;
        rd  = resp_rdata;
        mis = resp_misaligned;
        @(negedge Clk);
        after_valid = resp_valid;
        after_ready = req_ready;
    endtask

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; req_cycles = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({req_ready, resp_valid, resp_misaligned, mem_req, mem_we} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got ready/valid/mis/req/we=%b required 10000",
                     {req_ready, resp_valid, resp_misaligned, mem_req, mem_we});
        end
        checks++;
        if (resp_rdata !== 64'd0 || mem_addr !== 62'd0 || mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h addr=%h wdata=%h required zeros",
                     resp_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_load_byte();
        logic [63:0] rd; logic mis, av, ar; int lat;
        mem[2] = 32'h8899AABB; ref_mem[2] = 32'h8899AABB;
        ack_delay = 0; clear_counts();
        do_req(1'b0, 2'd0, 1'b1, 64'hB, 64'd0, rd, mis, lat, av, ar);
        checks++;
        if (rd !== 64'hFFFFFFFFFFFFFF88 || mis !== 1'b0) begin
            failures++; $display("FAIL load_byte got %h mis=%b required ffffffffffffff88 mis=0", rd, mis);
        end
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL load_byte_latency got %0d required 2", lat); end
        checks++;
        if (rd_cnt !== 1 || wr_cnt !== 0 || last_raddr !== 62'd2) begin
            failures++; $display("FAIL load_byte_bus got rd=%0d wr=%0d addr=%0d required 1 0 2", rd_cnt, wr_cnt, last_raddr);
        end
        checks++;
        if (av !== 1'b0 || ar !== 1'b1) begin
            failures++; $display("FAIL resp_pulse got valid=%b ready=%b required 0 1", av, ar);
        end
    endtask

    task automatic test_load_half_delay();
        logic [63:0] rd; logic mis, av, ar; int lat;
        ack_delay = 3; clear_counts();
        do_req(1'b0, 2'd1, 1'b0, 64'hA, 64'd0, rd, mis, lat, av, ar);
        ack_delay = 0;
        checks++;
        if (rd !== 64'h0000000000008899 || mis !== 1'b0) begin
            failures++; $display("FAIL load_half got %h mis=%b required 0000000000008899 mis=0", rd, mis);
        end
        checks++;
        if (req_cycles !== 4 || last_raddr !== 62'd2 || lat !== 5) begin
            failures++; $display("FAIL load_half_wait got req_cycles=%0d addr=%0d lat=%0d required 4 2 5",
                                 req_cycles, last_raddr, lat);
        end
    endtask

    task automatic test_store_byte();
        logic [63:0] rd; logic mis, av, ar; int lat;
        clear_counts();
        do_req(1'b1, 2'd0, 1'b0, 64'h9, 64'h5A, rd, mis, lat, av, ar);
        ref_mem[2] = model_store(ref_mem[2], 64'h9, 2'd0, 64'h5A);
        checks++;
        if (rd_cnt !== 1 || wr_cnt !== 1 || last_waddr !== 62'd2 || last_wdata !== 32'h88995ABB) begin
            failures++; $display("FAIL store_byte_bus got rd=%0d wr=%0d addr=%0d wdata=%h required 1 1 2 88995abb",
                                 rd_cnt, wr_cnt, last_waddr, last_wdata);
        end
        checks++;
        if (rd !== 64'd0 || mis !== 1'b0 || lat !== 3) begin
            failures++; $display("FAIL store_byte_resp got rdata=%h mis=%b lat=%0d required 0 0 3", rd, mis, lat);
        end
        do_req(1'b0, 2'd2, 1'b0, 64'h8, 64'd0, rd, mis, lat, av, ar);
        checks++;
        if (rd !== 64'h0000000088995ABB) begin
            failures++; $display("FAIL store_readback got %h required 0000000088995abb", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] rd; logic mis, av, ar; int lat;
        logic [1:0]  bhws  [3] = '{2'd2, 2'd1, 2'd3};
        logic        ws    [3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] addrs [3] = '{64'h6, 64'h3, 64'h4};
        for (int i = 0; i < 3; i++) begin
            clear_counts();
            do_req(ws[i], bhws[i], 1'b1, addrs[i], 64'hFFFF, rd, mis, lat, av, ar);
            checks++;
            if (mis !== 1'b1 || lat !== 1 || rd !== 64'd0 || req_cycles !== 0) begin
                failures++; $display("FAIL misaligned_%0d got mis=%b lat=%0d rdata=%h req_cycles=%0d required 1 1 0 0",
                                     i, mis, lat, rd, req_cycles);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0; int seen = 0;
        mem[4] = 32'hCAFEF00D; ref_mem[4] = 32'hCAFEF00D;
        hold_ack = 1'b1; clear_counts();
        @(negedge Clk);
        req_valid = 1'b1; req_write = 1'b1; req_bhw = 2'd2; req_addr = 64'h10; req_wdata = 64'h12345678;
        @(posedge Clk); #1 req_valid = 1'b0;
        @(negedge Clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            failures++; $display("FAIL reset_mid_pre got req=%b we=%b required 1 1", mem_req, mem_we);
        end
        Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_mid got req=%b ready=%b valid=%b required 0 1 0", mem_req, req_ready, resp_valid);
        end
        hold_ack = 1'b0;
        while (n < 6) begin
            if (resp_valid || mem_req) seen++;
            @(negedge Clk); n++;
        end
        checks++;
        if (seen !== 0 || mem[4] !== 32'hCAFEF00D || wr_cnt !== 0) begin
            failures++; $display("FAIL reset_mid_after got activity=%0d word4=%h writes=%0d required 0 cafef00d 0",
                                 seen, mem[4], wr_cnt);
        end
    endtask

    task automatic test_stray_ack();
        int seen = 0;
        @(negedge Clk);
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (resp_valid || mem_req || !req_ready) seen++;
        end
        stray_ack = 1'b0;
        @(negedge Clk);
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL stray_ack got %0d bad cycles required 0", seen); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0, acc = 0, got = 0, overlap = 0;
        int acc_cyc [2] = '{0, 0};
        int resp_cyc [2] = '{0, 0};
        logic [63:0] dat [2] = '{64'd0, 64'd0};
        mem[5] = 32'h80000001; ref_mem[5] = 32'h80000001;
        mem[6] = 32'h01F2E3D4; ref_mem[6] = 32'h01F2E3D4;
        ack_delay = 0;
        @(posedge Clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_bhw = 2'd2; req_sign = 1'b1; req_addr = 64'h14;
        while (cyc < 40 && got < 2) begin
            @(negedge Clk); cyc++;
            if (mem_req && resp_valid) overlap++;
            if (resp_valid) begin resp_cyc[got] = cyc; dat[got] = resp_rdata; got++; end
            if (req_valid && req_ready && acc < 2) begin
                acc_cyc[acc] = cyc; acc++;
                @(posedge Clk); #1;
                if (acc == 1) begin req_bhw = 2'd0; req_sign = 1'b0; req_addr = 64'h1B; end
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (got !== 2 || dat[0] !== model_load(ref_mem[5], 64'h14, 2'd2, 1'b1) ||
            dat[1] !== model_load(ref_mem[6], 64'h1B, 2'd0, 1'b0)) begin
            failures++; $display("FAIL b2b_data got n=%0d %h %h required 2 %h %h", got, dat[0], dat[1],
                                 model_load(ref_mem[5], 64'h14, 2'd2, 1'b1), model_load(ref_mem[6], 64'h1B, 2'd0, 1'b0));
        end
        checks++;
        if (acc !== 2 || acc_cyc[1] !== resp_cyc[0] + 1 || overlap !== 0) begin
            failures++; $display("FAIL b2b_timing got accept2=%0d resp1=%0d overlap=%0d required accept2=resp1+1 overlap=0",
                                 acc_cyc[1], resp_cyc[0], overlap);
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, wd, a, exp_rd; logic mis, av, ar, w, s, exp_mis; logic [1:0] bhw;
        int lat, d, exp_lat, exp_rds, exp_wrs, idx, errs = 0;
        for (int t = 0; t < 60; t++) begin
            idx = $urandom_range(0, 63);
            a   = 64'(idx * 4 + $urandom_range(0, 3));
            bhw = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 1));
            wd  = {$urandom, $urandom};
            d   = $urandom_range(0, 2);
            ack_delay = d; clear_counts();
            exp_mis = model_mis(bhw, a);
            exp_rd  = (w || exp_mis) ? 64'd0 : model_load(ref_mem[idx], a, bhw, s);
            exp_rds = (exp_mis || (w && bhw == 2'd2)) ? 0 : 1;
            exp_wrs = (exp_mis || !w) ? 0 : 1;
            exp_lat = 1 + (exp_rds + exp_wrs) * (1 + d);
            do_req(w, bhw, s, a, wd, rd, mis, lat, av, ar);
            if (w && !exp_mis) ref_mem[idx] = model_store(ref_mem[idx], a, bhw, wd);
            checks++;
            if (rd !== exp_rd || mis !== exp_mis || lat !== exp_lat || rd_cnt !== exp_rds ||
                wr_cnt !== exp_wrs || mem[idx] !== ref_mem[idx] || av !== 1'b0 || ar !== 1'b1) begin
                failures++; errs++;
                if (errs < 10)
                    $display("FAIL random_%0d w=%b bhw=%0d a=%h got rd=%h mis=%b lat=%0d r/w=%0d/%0d word=%h required rd=%h mis=%b lat=%0d r/w=%0d/%0d word=%h",
                             t, w, bhw, a, rd, mis, lat, rd_cnt, wr_cnt, mem[idx], exp_rd, exp_mis, exp_lat,
                             exp_rds, exp_wrs, ref_mem[idx]);
            end
        end
        ack_delay = 0;
        checks++;
        if (stab_err !== 0) begin failures++; $display("FAIL bus_stability got %0d changes required 0", stab_err); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_load_byte();
        test_load_half_delay();
        test_store_byte();
        test_misaligned();
        test_reset_mid();
        test_stray_ack();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
